// File: rtl/md_sched.sv
// HI/LO multiply/divide sequencer: owns HI/LO, models MULT/DIV latency, stalls D while occupied.
// Optional macro MD_PERF_CNT_EN adds the stall_cnt stall-cycle counter output.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_valid,
    input  logic [2:0]  md_op,
    input  logic        md_flush,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        md_use_d,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        start,
    output logic        busy,
    output logic        stall,
`ifdef MD_PERF_CNT_EN
    output logic [31:0] stall_cnt,
`endif
    output logic        dbg_state
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [3:0] MULT_LAST = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LAST  = 4'(DIV_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] pend_q, pend_d;
    logic [31:0] hi_d, lo_d;
    logic        accept;
    logic [63:0] result;

    logic [63:0]        mul_s, mul_u;
    logic [31:0]        rt_sdiv, rt_udiv;
    logic signed [31:0] quot_s, rem_s;

    assign mul_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    assign mul_u = {32'd0, rs} * {32'd0, rt};

    // Divisor forced to 1 for /0 and for MIN/-1: the latter then yields MIN rem 0, exactly the wrapped result.
    assign rt_sdiv = ((rt == 32'd0) || (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF)) ? 32'd1 : rt;
    assign rt_udiv = (rt == 32'd0) ? 32'd1 : rt;
    assign quot_s  = $signed(rs) / $signed(rt_sdiv);
    assign rem_s   = $signed(rs) % $signed(rt_sdiv);

    // Divide by zero latches the current HI/LO so completion leaves them untouched.
    always_comb begin
        result = {hi, lo};
        case (md_op)
            3'd1: result = mul_s;
            3'd2: result = mul_u;
            3'd3: if (rt != 32'd0) result = {rem_s, quot_s};
            3'd4: if (rt != 32'd0) result = {rs % rt_udiv, rs / rt_udiv};
            default: result = {hi, lo};
        endcase
    end

    assign accept    = md_valid & ~md_flush & (state_q == IDLE);
    assign start     = accept & (md_op >= 3'd1) & (md_op <= 3'd4);
    assign busy      = (state_q == BUSY);
    assign stall     = md_use_d & (start | busy);
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hi_d    = hi;
        lo_d    = lo;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pend_d  = result;
                    state_d = BUSY;
                    cnt_d   = (md_op <= 3'd2) ? MULT_LAST : DIV_LAST;
                end else if (accept && md_op == 3'd5) begin
                    hi_d = rs;
                end else if (accept && md_op == 3'd6) begin
                    lo_d = rs;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    hi_d    = pend_q[63:32];
                    lo_d    = pend_q[31:0];
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            pend_q  <= 64'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hi      <= hi_d;
            lo      <= lo_d;
        end
    end

`ifdef MD_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stall_cnt <= 32'd0;
        else if (stall) stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_md_sched.sv
// Randomized and directed bench for md_sched: scoreboard of completed HI/LO results plus inline checks.
module tb_md_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        md_valid = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic        md_flush = 1'b0;
    logic [31:0] rs = 32'd0;
    logic [31:0] rt = 32'd0;
    logic        md_use_d = 1'b0;
    logic [31:0] hi, lo;
    logic        start, busy, stall, dbg_state;
`ifdef MD_PERF_CNT_EN
    logic [31:0] stall_cnt;
    int unsigned m_stall_cnt = 0;
`endif

    md_sched dut (
        .clk(clk), .reset(reset), .md_valid(md_valid), .md_op(md_op), .md_flush(md_flush),
        .rs(rs), .rt(rt), .md_use_d(md_use_d), .hi(hi), .lo(lo), .start(start),
        .busy(busy), .stall(stall),
`ifdef MD_PERF_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // {busy length[7:0], hi, lo}
    logic [71:0] exp_q[$];
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    logic [63:0] m_pend = 64'd0;
    bit          m_busy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural meaning of each op.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] cur);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur, p;
        logic [63:0]     v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd1: begin q = sa * sb; v = q; return v; end
            3'd2: begin p = ua * ub; v = p; return v; end
            3'd3: begin
                if (b == 32'd0) return cur;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 32'd0) return cur;
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            default: return cur;
        endcase
    endfunction

    // monitor: measures each busy run and checks HI/LO on the first idle cycle
    initial begin
        int run;
        logic [71:0] e;
        run = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                run = 0;
            end else if (busy) begin
                run++;
            end else if (run > 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_busy_run", 64'(run), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("busy_len", 64'(run), 64'(e[71:64]));
                    check("hi_done", {32'd0, hi}, {32'd0, e[63:32]});
                    check("lo_done", {32'd0, lo}, {32'd0, e[31:0]});
                end
                run = 0;
            end
        end
    end

`ifdef MD_PERF_CNT_EN
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!reset) m_stall_cnt = 0;
            else if (stall) m_stall_cnt++;
        end
    end
`endif

    // driver: present one op for one cycle, check the combinational outputs and any MTHI/MTLO effect
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit fl);
        bit acc, is_md;
        @(negedge clk);
        md_valid = 1'b1; md_op = op; rs = a; rt = b; md_flush = fl;
        #1;
        acc   = !fl && !m_busy;
        is_md = (op >= 3'd1) && (op <= 3'd4);
        check("start", {63'd0, start}, {63'd0, acc && is_md});
        check("stall_issue", {63'd0, stall}, {63'd0, md_use_d && ((acc && is_md) || m_busy)});
        if (acc && is_md) begin
            m_pend = model(op, a, b, {m_hi, m_lo});
            exp_q.push_back({(op <= 3'd2) ? 8'd5 : 8'd10, m_pend});
            m_busy = 1'b1;
        end else if (acc && op == 3'd5) begin
            m_hi = a;
        end else if (acc && op == 3'd6) begin
            m_lo = a;
        end
        @(negedge clk);
        md_valid = 1'b0; md_op = 3'd0; md_flush = 1'b0; rs = $urandom; rt = $urandom;
        #1;
        check("hi_arch", {32'd0, hi}, {32'd0, m_hi});
        check("lo_arch", {32'd0, lo}, {32'd0, m_lo});
        check("busy_after_issue", {63'd0, busy}, {63'd0, m_busy});
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while (busy) begin
            check("stall_busy", {63'd0, stall}, {63'd0, md_use_d});
            @(negedge clk);
            #1;
            cyc++;
            if (cyc > 40) begin
                check("wait_idle_timeout", 64'(cyc), 64'd0);
                break;
            end
        end
        if (m_busy) begin
            m_hi = m_pend[63:32];
            m_lo = m_pend[31:0];
            m_busy = 1'b0;
        end
        check("hi_idle", {32'd0, hi}, {32'd0, m_hi});
        check("lo_idle", {32'd0, lo}, {32'd0, m_lo});
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        bit          fl;

        repeat (3) @(negedge clk);
        #1;
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_start", {63'd0, start}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        #2 reset = 1'b1;
        md_use_d = 1'b1;

        issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0); wait_idle();
        check("mult_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
        check("mult_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFE);
        issue(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0); wait_idle();
        check("multu_hi", {32'd0, hi}, 64'h1);
        issue(3'd4, 32'd7, 32'd2, 1'b0); wait_idle();
        check("divu_lo", {32'd0, lo}, 64'd3);
        check("divu_hi", {32'd0, hi}, 64'd1);
        issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0); wait_idle();
        check("div_neg_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
        check("div_neg_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); wait_idle();
        check("div_ovf_lo", {32'd0, lo}, 64'h0000_0000_8000_0000);
        check("div_ovf_hi", {32'd0, hi}, 64'd0);

        issue(3'd5, 32'h1234_5678, 32'd0, 1'b0);
        issue(3'd3, 32'd99, 32'd0, 1'b0);
        issue(3'd1, 32'd3, 32'd4, 1'b0);
        wait_idle();
        check("div0_hi", {32'd0, hi}, 64'h0000_0000_1234_5678);
        check("div0_lo", {32'd0, lo}, 64'h0000_0000_8000_0000);

        issue(3'd1, 32'd5, 32'd6, 1'b1);
        check("flush_busy", {63'd0, busy}, 64'd0);
        issue(3'd1, 32'd5, 32'd6, 1'b0);
        issue(3'd3, 32'd1, 32'd1, 1'b1);
        wait_idle();
        check("flush_busy_lo", {32'd0, lo}, 64'd30);

        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 9));
            fl = ($urandom_range(0, 7) == 0);
            md_use_d = ($urandom_range(0, 1) == 1);
            issue(op, a, b, fl);
            wait_idle();
        end

        md_use_d = 1'b1;
        issue(3'd3, 32'd1000, 32'd7, 1'b0);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_hi", {32'd0, hi}, 64'd0);
        check("arst_lo", {32'd0, lo}, 64'd0);
        exp_q.delete();
        m_busy = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        #2 reset = 1'b1;
        issue(3'd6, 32'hA5A5_A5A5, 32'd0, 1'b0);
        check("mtlo_lo", {32'd0, lo}, 64'h0000_0000_A5A5_A5A5);
        issue(3'd1, 32'd2, 32'd3, 1'b0); wait_idle();

        repeat (2) @(negedge clk);
        #5;
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
`ifdef MD_PERF_CNT_EN
        check("stall_cnt", {32'd0, stall_cnt}, 64'(m_stall_cnt));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Sequencing controller for the HI/LO multiply/divide resource in the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and models the multi-cycle latency.
- Owns the HI/LO registers and raises a D-stage stall while the unit is occupied.
- Sits beside the E-stage ALU; the stall feeds the hazard unit, and HI/LO feed the MFHI/MFLO forwarding mux.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
md_valid  in  1  E-stage instruction is a HI/LO op
md_op  in  3  1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO; 0/7 = no-op
md_flush  in  1  E-stage instruction is being killed (exception/interrupt) this cycle
rs  in  32  forwarded rs operand
rt  in  32  forwarded rt operand
md_use_d  in  1  D-stage instruction is any of MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO
hi  out  32  HI register
lo  out  32  LO register
start  out  1  combinational: an accepted mult/div issue this cycle
busy  out  1  registered: unit occupied
stall  out  1  combinational: freeze D stage

Behaviour:
- States: IDLE and BUSY, with a 4-bit down-counter cnt.
- Reset (reset=0, asynchronous):
  - State goes to IDLE; cnt=0.
  - hi=0, lo=0, busy=0.
  - start=0 and stall=0 follow from IDLE.
- Accept condition: md_valid & !md_flush & state==IDLE.
- start = accept & md_op in {1..4}.
- Issue edge, MULT/MULTU/DIV/DIVU:
  - Latch the 64-bit result into an internal pending register: {hi,lo}.
  - MULT: signed 64-bit product; MULTU: unsigned.
  - DIV: lo=quotient, hi=remainder, signed, truncating toward zero, remainder takes the dividend's sign.
  - DIVU: unsigned.
  - Go to BUSY with cnt=N-1, where N=MULT_CYCLES or DIV_CYCLES.
- In BUSY:
  - busy=1; cnt decrements every edge.
  - On the edge where cnt==0: copy pending into hi/lo and return to IDLE.
  - Net effect: busy is high for exactly N cycles after the issue edge; new hi/lo are visible in the first cycle busy is 0.
- MTHI/MTLO, accepted in IDLE: hi (resp. lo) <= rs at the next edge; no busy cycles.
- stall = md_use_d & (start | busy).
- Divide by zero (rt=0 on DIV/DIVU):
  - Still takes DIV_CYCLES busy cycles.
  - hi/lo keep their pre-issue values at completion.
- DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- Any md_valid while BUSY: ignored, no state change. The upstream stall normally prevents this.
- md_flush in the issue cycle: op discarded; no start, no busy, hi/lo unchanged.
- md_flush while BUSY: no effect; the in-flight op completes and is architecturally committed.
- Reset mid-BUSY: aborts immediately; hi=lo=0; the pending result is discarded.
- md_op 0 or 7 with md_valid=1: no-op.

Optional Feature:
- Macro: MD_PERF_CNT_EN.
- Defined:
  - Adds output stall_cnt[31:0], reset to 0.
  - Increments by 1 on every rising edge where stall=1.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. MULT rs=0xFFFFFFFF rt=0x00000002; md_use_d=1 throughout → start pulses 1 cycle, then busy=1 for 5 cycles and stall=1 for 6 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
2. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles. DIVU rs=7 rt=2 → busy 10 cycles, then lo=3, hi=1.
3. DIV rs=0xFFFFFFF9 (-7) rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV rs=0x80000000 rt=0xFFFFFFFF → lo=0x80000000, hi=0.
4. MTHI rs=0x12345678, then DIV with rt=0 → hi stays 0x12345678 and lo is unchanged after 10 busy cycles. A second MULT presented during busy is ignored.
5. MULT with md_flush=1 in the issue cycle → start=0, busy stays 0, hi/lo unchanged. MULT accepted, then md_flush=1 two cycles later → result still committed after 5 cycles.
6. Start DIV, drive reset=0 mid-busy (asynchronously, between edges) → busy=0 and hi=lo=0 immediately. After release, MTLO rs=0xA5A5A5A5 → lo=0xA5A5A5A5 one edge later. With MD_PERF_CNT_EN: stall_cnt equals the number of stall cycles counted from reset release.
